// File: rtl/button_debounce_pkg.sv
// Shared definitions for the button debouncer.
//   state_t       : FSM state encoding
//   ms_to_cycles  : converts a time in milliseconds to clock cycles
package button_debounce_pkg;

  typedef enum logic [1:0] {
    RELEASED     = 2'b00,
    PRESS_WAIT   = 2'b01,
    PRESSED      = 2'b10,
    RELEASE_WAIT = 2'b11
  } state_t;

  // freq_hz is a multiple of 1000, so dividing first keeps the product in range.
  function automatic int unsigned ms_to_cycles(input int unsigned freq_hz,
                                               input int unsigned msecs);
    return (freq_hz / 1000) * msecs;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input pin.
//   clk_i : destination clock
//   rst_i : asynchronous active-high reset, loads INIT into both flops
//   d_i   : asynchronous input
//   q_o   : synchronized output (two cycles of latency)
module sync_2ff #(
  parameter logic INIT = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_meta <= INIT;
      r_sync <= INIT;
    end else begin
      r_meta <= d_i;
      r_sync <= r_meta;
    end
  end

  assign q_o = r_sync;

endmodule

// File: rtl/button_debounce.sv
// Debouncer for a mechanical button with press/release/long-press pulses.
//   clk_i     : clock, rising edge
//   rst_i     : asynchronous active-high reset
//   btn_i     : raw asynchronous button pin (ACTIVE level = pressed)
//   level_o   : debounced state, 1 = pressed
//   press_o   : one-cycle pulse on a debounced press
//   release_o : one-cycle pulse on a debounced release
//   long_o    : one-cycle pulse once a press has lasted LNG cycles
module button_debounce
  import button_debounce_pkg::*;
#(
  parameter int unsigned FREQ       = 125000000,
  parameter int unsigned MSECS      = 20,
  parameter int unsigned LONG_MSECS = 1000,
  parameter logic        ACTIVE     = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic long_o
);

  localparam int unsigned DEB = ms_to_cycles(FREQ, MSECS);
  localparam int unsigned LNG = ms_to_cycles(FREQ, LONG_MSECS);
  localparam int unsigned DW  = $clog2(DEB);
  localparam int unsigned LW  = $clog2(LNG + 1);

  localparam logic [DW-1:0] DEB_LAST = DW'(DEB - 1);
  localparam logic [LW-1:0] LNG_MAX  = LW'(LNG);
  localparam logic [LW-1:0] LNG_PRE  = LW'(LNG - 1);

  logic          w_sync;
  logic          w_act;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [DW-1:0] r_deb_cnt;
  logic [DW-1:0] w_deb_nxt;
  logic [LW-1:0] r_long_cnt;
  logic [LW-1:0] w_long_nxt;
  logic [LW-1:0] w_long_sat;
  logic          w_long_hit;

  logic          r_level;
  logic          r_press;
  logic          r_release;
  logic          r_long;
  logic          w_level_nxt;
  logic          w_press_nxt;
  logic          w_release_nxt;
  logic          w_long_pulse_nxt;

  sync_2ff #(
    .INIT (~ACTIVE)
  ) u_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (btn_i),
    .q_o   (w_sync)
  );

  assign w_act = (w_sync == ACTIVE);

  // Saturating long-press count; the hit flag marks the single step onto LNG,
  // which is what keeps long_o from repeating within one press.
  assign w_long_sat = (r_long_cnt == LNG_MAX) ? r_long_cnt : r_long_cnt + LW'(1);
  assign w_long_hit = (r_long_cnt == LNG_PRE);

  always_comb begin
    w_state_nxt      = r_state;
    w_deb_nxt        = r_deb_cnt;
    w_long_nxt       = r_long_cnt;
    w_press_nxt      = 1'b0;
    w_release_nxt    = 1'b0;
    w_long_pulse_nxt = 1'b0;

    case (r_state)
      RELEASED: begin
        if (w_act) begin
          w_state_nxt = PRESS_WAIT;
          w_deb_nxt   = '0;
        end
      end

      PRESS_WAIT: begin
        if (!w_act) begin
          w_state_nxt = RELEASED;
        end else if (r_deb_cnt == DEB_LAST) begin
          w_state_nxt = PRESSED;
          w_press_nxt = 1'b1;
          w_long_nxt  = '0;
        end else begin
          w_deb_nxt = r_deb_cnt + DW'(1);
        end
      end

      PRESSED: begin
        w_long_nxt       = w_long_sat;
        w_long_pulse_nxt = w_long_hit;
        if (!w_act) begin
          w_state_nxt = RELEASE_WAIT;
          w_deb_nxt   = '0;
        end
      end

      RELEASE_WAIT: begin
        // The button still counts as held while a release is being confirmed,
        // so a rejected release bounce leaves the long-press timing untouched.
        // On the confirming cycle the long count is frozen so long_o can never
        // coincide with release_o.
        if (w_act) begin
          w_state_nxt      = PRESSED;
          w_long_nxt       = w_long_sat;
          w_long_pulse_nxt = w_long_hit;
        end else if (r_deb_cnt == DEB_LAST) begin
          w_state_nxt   = RELEASED;
          w_release_nxt = 1'b1;
        end else begin
          w_deb_nxt        = r_deb_cnt + DW'(1);
          w_long_nxt       = w_long_sat;
          w_long_pulse_nxt = w_long_hit;
        end
      end

      default: begin
        w_state_nxt = RELEASED;
        w_deb_nxt   = '0;
        w_long_nxt  = '0;
      end
    endcase

    w_level_nxt = (w_state_nxt == PRESSED) || (w_state_nxt == RELEASE_WAIT);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= RELEASED;
      r_deb_cnt  <= '0;
      r_long_cnt <= '0;
      r_level    <= 1'b0;
      r_press    <= 1'b0;
      r_release  <= 1'b0;
      r_long     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_deb_cnt  <= w_deb_nxt;
      r_long_cnt <= w_long_nxt;
      r_level    <= w_level_nxt;
      r_press    <= w_press_nxt;
      r_release  <= w_release_nxt;
      r_long     <= w_long_pulse_nxt;
    end
  end

  assign level_o   = r_level;
  assign press_o   = r_press;
  assign release_o = r_release;
  assign long_o    = r_long;

endmodule

// File: tb/tb_button_debounce.sv
// Testbench for button_debounce (FREQ=1000, MSECS=4, LONG_MSECS=10, ACTIVE=1:
// DEB=4, LNG=10). Stimulus queues the expected pulses with their cycle
// numbers; a monitor pops and compares whenever the DUT emits a pulse.
module tb_button_debounce;

  localparam int PRESS_LAT = 7;   // negedge drive -> pulse seen at negedge: 1 + 2 + DEB
  localparam int LONG_LAT  = 10;  // press_o -> long_o

  typedef enum int {EV_PRESS = 0, EV_RELEASE = 1, EV_LONG = 2} ev_kind_t;
  typedef struct {
    ev_kind_t kind;
    int       cyc;
  } ev_t;

  logic clk = 1'b0;
  logic rst;
  logic btn;
  logic level_o, press_o, release_o, long_o;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  ev_t  exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  button_debounce #(
    .FREQ       (1000),
    .MSECS      (4),
    .LONG_MSECS (10),
    .ACTIVE     (1'b1)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .btn_i     (btn),
    .level_o   (level_o),
    .press_o   (press_o),
    .release_o (release_o),
    .long_o    (long_o)
  );

  // Monitor / scoreboard
  always @(negedge clk) begin : monitor
    ev_kind_t k;
    ev_t      e;
    if (press_o || release_o || long_o) begin
      n_checks++;
      if ($countones({press_o, release_o, long_o}) != 1) begin
        n_fail++;
        $display("FAIL pulse_exclusive: cycle %0d got press=%b release=%b long=%b, required exactly one",
                 cyc, press_o, release_o, long_o);
      end
      k = press_o ? EV_PRESS : (release_o ? EV_RELEASE : EV_LONG);
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_pulse: got %s at cycle %0d, required no pulse", k.name(), cyc);
      end else begin
        e = exp_q.pop_front();
        if (e.kind != k || e.cyc != cyc) begin
          n_fail++;
          $display("FAIL pulse_event: got %s at cycle %0d, required %s at cycle %0d",
                   k.name(), cyc, e.kind.name(), e.cyc);
        end
      end
    end
  end

  task automatic expect_ev(input ev_kind_t k, input int c);
    ev_t e;
    e.kind = k;
    e.cyc  = c;
    exp_q.push_back(e);
  endtask

  task automatic check(input string name, input logic got, input logic req);
    n_checks++;
    if (got !== req) begin
      n_fail++;
      $display("FAIL %s: cycle %0d got %b, required %b", name, cyc, got, req);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Release the button and expect release_o; leave time to settle.
  task automatic do_release();
    btn = 1'b0;
    expect_ev(EV_RELEASE, cyc + PRESS_LAT);
    tick(12);
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int   t;
    logic ok;
    rst = 1'b0;
    btn = 1'b0;
    #1 rst = 1'b1;
    #2;
    check("reset_level",   level_o,   1'b0);
    check("reset_press",   press_o,   1'b0);
    check("reset_release", release_o, 1'b0);
    check("reset_long",    long_o,    1'b0);
    tick(3);
    rst = 1'b0;
    tick(3);

    // Clean press, long press, clean release
    t = cyc;
    btn = 1'b1;
    expect_ev(EV_PRESS, t + PRESS_LAT);
    expect_ev(EV_LONG,  t + PRESS_LAT + LONG_LAT);
    tick(9);
    #1 check("clean_level_after_press", level_o, 1'b1);
    tick(12);
    t = cyc;
    btn = 1'b0;
    expect_ev(EV_RELEASE, t + PRESS_LAT);
    tick(6);
    #1 check("clean_level_release_wait", level_o, 1'b1);
    tick(2);
    #1 check("clean_level_released", level_o, 1'b0);
    tick(4);

    // Press bounce: 3 high cycles rejected, then a held press
    btn = 1'b1;
    tick(3);
    btn = 1'b0;
    ok = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      if (level_o !== 1'b0) ok = 1'b0;
    end
    check("bounce_level_stays_low", ok, 1'b1);
    t = cyc;
    btn = 1'b1;
    expect_ev(EV_PRESS, t + PRESS_LAT);
    expect_ev(EV_LONG,  t + PRESS_LAT + LONG_LAT);
    tick(20);
    do_release();

    // Release bounce while pressed: long_o timing unchanged
    t = cyc;
    btn = 1'b1;
    expect_ev(EV_PRESS, t + PRESS_LAT);
    expect_ev(EV_LONG,  t + PRESS_LAT + LONG_LAT);
    tick(10);
    btn = 1'b0;
    tick(2);
    btn = 1'b1;
    ok = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick(1);
      if (level_o !== 1'b1) ok = 1'b0;
    end
    check("release_bounce_level_high", ok, 1'b1);
    tick(6);
    do_release();

    // Short press: 8 cycles, no long_o
    t = cyc;
    btn = 1'b1;
    expect_ev(EV_PRESS,   t + PRESS_LAT);
    expect_ev(EV_RELEASE, t + 8 + PRESS_LAT);
    tick(8);
    btn = 1'b0;
    tick(20);
    #1 check("short_level_low", level_o, 1'b0);

    // Reset during PRESS_WAIT with button held
    btn = 1'b1;
    tick(4);
    rst = 1'b1;
    #1;
    check("rst_pw_level",   level_o, 1'b0);
    check("rst_pw_press",   press_o, 1'b0);
    tick(2);
    rst = 1'b0;
    t = cyc;
    expect_ev(EV_PRESS, t + PRESS_LAT);
    expect_ev(EV_LONG,  t + PRESS_LAT + LONG_LAT);
    tick(20);
    do_release();

    // Reset mid-press: pending long discarded, no release, fresh press
    t = cyc;
    btn = 1'b1;
    expect_ev(EV_PRESS, t + PRESS_LAT);
    tick(12);
    #1 check("rst_mid_level_before", level_o, 1'b1);
    rst = 1'b1;
    #1 check("rst_mid_level_forced", level_o, 1'b0);
    tick(2);
    rst = 1'b0;
    t = cyc;
    expect_ev(EV_PRESS, t + PRESS_LAT);
    expect_ev(EV_LONG,  t + PRESS_LAT + LONG_LAT);
    tick(9);
    #1 check("rst_mid_repress_level", level_o, 1'b1);
    tick(12);
    do_release();

    tick(5);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL missing_pulses: %0d expected pulses never seen, required 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/button_debounce.md
BUTTON_DEBOUNCE -- requirements
Module: button_debounce

Interface
REQ-001 The block SHALL have parameter FREQ, default 125000000: clock frequency in Hz, a multiple of 1000.
REQ-002 The block SHALL have parameter MSECS, default 20: debounce time in ms; DEB = FREQ/1000*MSECS cycles, DEB >= 2.
REQ-003 The block SHALL have parameter LONG_MSECS, default 1000: long-press time in ms; LNG = FREQ/1000*LONG_MSECS cycles, LNG > DEB.
REQ-004 The block SHALL have parameter ACTIVE, default 1'b0: the btn_i level that means pressed.
REQ-005 The block SHALL have port clk_i, input, 1 bit: the only clock, rising edge.
REQ-006 The block SHALL have port rst_i, input, 1 bit: reset, asynchronous and active-high.
REQ-007 The block SHALL have port btn_i, input, 1 bit: raw asynchronous button/switch pin.
REQ-008 The block SHALL have port level_o, output, 1 bit: debounced state, 1 = pressed.
REQ-009 The block SHALL have port press_o, output, 1 bit: one-cycle pulse on debounced press.
REQ-010 The block SHALL have port release_o, output, 1 bit: one-cycle pulse on debounced release.
REQ-011 The block SHALL have port long_o, output, 1 bit: one-cycle pulse when a press has lasted LNG cycles.

Function
REQ-012 btn_i SHALL pass through a 2-flop synchronizer; act = (synchronized value == ACTIVE).
REQ-013 The FSM SHALL have four states: RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT.
REQ-014 RELEASED: act=1 -> PRESS_WAIT, debounce counter cleared to 0; act=0 -> stay.
REQ-015 PRESS_WAIT: act=0 -> RELEASED (bounce rejected, no pulse); act=1 and counter = DEB-1 -> PRESSED; otherwise counter +1.
REQ-016 PRESSED: act=0 -> RELEASE_WAIT, debounce counter cleared; the long counter increments each cycle, saturating at LNG.
REQ-017 RELEASE_WAIT: act=1 -> PRESSED (bounce rejected, long counter NOT cleared); act=0 and counter = DEB-1 -> RELEASED; otherwise counter +1.
REQ-018 press_o SHALL be 1 exactly in the first cycle of PRESSED entered from PRESS_WAIT; the long counter is cleared then.
REQ-019 release_o SHALL be 1 exactly in the first cycle of RELEASED entered from RELEASE_WAIT.
REQ-020 long_o SHALL pulse once, in the cycle the long counter reaches LNG; it SHALL not repeat until a new press_o.
REQ-021 level_o SHALL be 1 in PRESSED and RELEASE_WAIT, 0 otherwise.
REQ-022 Latency: for a clean btn_i edge, press_o/release_o SHALL assert 2+DEB cycles after the first clk_i edge sampling the new level.
REQ-023 All outputs SHALL be registered; press_o, release_o and long_o are mutually exclusive in any cycle.
REQ-024 Counter widths SHALL be $clog2(DEB) and $clog2(LNG+1); no wrap-around is permitted.

Reset
REQ-025 rst_i=1 SHALL immediately force: synchronizer flops to ~ACTIVE, state RELEASED, counters 0, all outputs 0.
REQ-026 A button held through reset release SHALL be reported as a new press after 2+DEB cycles; no release_o is generated for the pre-reset press.
REQ-027 Reset asserted mid-debounce or mid-press SHALL discard the pending event with no pulse.

Structure
REQ-028 A shared package SHALL hold the FSM state encoding and the ms-to-cycles constant function.
REQ-029 The synchronizer SHALL be a sub-module named sync_2ff (parameter INIT), reusable for other pins.

Verification (FREQ=1000, MSECS=4, LONG_MSECS=10: DEB=4, LNG=10, ACTIVE=1)
REQ-030 Clean press: btn_i 0->1 held -> press_o at cycle 6 after the edge, level_o=1 thereafter, long_o 10 cycles after press_o.
REQ-031 Bounce: btn_i high 3 cycles then low -> no press_o and level_o stays 0; then held high -> press_o 6 cycles after the final rise.
REQ-032 Release bounce: while pressed, btn_i low 2 cycles then high -> no release_o, level_o stays 1, long_o timing unchanged.
REQ-033 Short press: held 8 cycles -> press_o once, release_o once, long_o never.
REQ-034 Reset: rst_i pulsed during PRESS_WAIT with btn_i held high -> outputs 0 immediately, press_o 6 cycles after rst_i falls.
